// File: rtl/wall_trace_sequencer.sv
// rtl/wall_trace_sequencer.sv - issues one wall trace per scanline and turns the result into a centred wall span
// Trace results are double-buffered: captured mid-blanking, shown from the following line.
module wall_trace_sequencer #(
  parameter int H_VIEW    = 640,
  parameter int H_TOTAL   = 800,
  parameter int V_ROWS    = 480,
  parameter int V_TOTAL   = 525,
  parameter int RUN_START = 640,
  parameter int RUN_LEN   = 150
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic [9:0]  i_hpos,
  input  logic [9:0]  i_vpos,
  input  logic        i_side,
  input  logic [10:0] i_size,
  output logic        o_run,
  output logic [9:0]  o_row,
  output logic        o_wall,
  output logic        o_side,
  output logic        o_valid
);

  localparam int CW = $clog2(RUN_LEN + 1);
  localparam logic [9:0]    L_RUN_START = 10'(RUN_START);
  localparam logic [9:0]    L_HLAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    L_VLAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    L_VROWS     = 10'(V_ROWS);
  localparam logic [10:0]   L_VIEW      = 11'(H_VIEW);
  localparam logic [10:0]   L_CENTRE    = 11'(H_VIEW / 2);
  localparam logic [CW-1:0] L_CNT_INIT  = CW'(RUN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE, S_HOLD} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pend_valid;
  logic          r_pend_side;
  logic [10:0]   r_pend_size;
  logic [10:0]   r_disp_size;

  logic [9:0]    w_trow;
  logic          w_start;
  logic          w_last;
  logic [10:0]   w_hpos;
  logic [10:0]   w_half;
  logic [10:0]   w_sum;
  logic [10:0]   w_left;
  logic [10:0]   w_right;
  logic          w_in_span;

  assign w_trow  = (i_vpos == L_VLAST) ? 10'd0 : i_vpos + 10'd1;
  assign w_start = (i_hpos == L_RUN_START) && (w_trow < L_VROWS);
  assign w_last  = (i_hpos == L_HLAST);

  // Span is [centre-half, centre+half), saturated to the visible line on both sides.
  assign w_hpos    = {1'b0, i_hpos};
  assign w_half    = r_disp_size >> 1;
  assign w_sum     = L_CENTRE + w_half;
  assign w_left    = (w_half > L_CENTRE) ? 11'd0 : L_CENTRE - w_half;
  assign w_right   = (w_sum > L_VIEW) ? L_VIEW : w_sum;
  assign w_in_span = o_valid && (w_hpos >= w_left) && (w_hpos < w_right) && (w_hpos < L_VIEW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_side  <= 1'b0;
      r_pend_size  <= '0;
      r_disp_size  <= '0;
      o_run        <= 1'b0;
      o_row        <= '0;
      o_wall       <= 1'b0;
      o_side       <= 1'b0;
      o_valid      <= 1'b0;
    end else if (vsync) begin
      r_state      <= S_IDLE;
      o_run        <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_side  <= 1'b0;
      r_pend_size  <= '0;
      r_disp_size  <= '0;
      o_side       <= 1'b0;
      o_valid      <= 1'b0;
      o_wall       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RUN;
            o_run   <= 1'b1;
            o_row   <= w_trow;
            r_cnt   <= L_CNT_INIT;
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            o_run   <= 1'b0;
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CAPTURE: begin
          r_pend_valid <= 1'b1;
          r_pend_side  <= i_side;
          r_pend_size  <= i_size;
          r_state      <= S_HOLD;
        end
        S_HOLD: begin
          if (w_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // End of line: show what was traced this line, then forget it.
      if (w_last) begin
        o_valid      <= r_pend_valid;
        o_side       <= r_pend_side;
        r_disp_size  <= r_pend_size;
        r_pend_valid <= 1'b0;
        r_pend_side  <= 1'b0;
        r_pend_size  <= '0;
      end

      o_wall <= w_in_span;
    end
  end

endmodule

// File: tb/tb_wall_trace_sequencer.sv
// tb/tb_wall_trace_sequencer.sv - directed table-driven bench for wall_trace_sequencer
module tb_wall_trace_sequencer;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset_n;
  logic        vsync;
  logic [9:0]  i_hpos;
  logic [9:0]  i_vpos;
  logic        i_side;
  logic [10:0] i_size;
  logic        o_run;
  logic [9:0]  o_row;
  logic        o_wall;
  logic        o_side;
  logic        o_valid;

  int n_tests = 0;
  int n_fail  = 0;

  int run_n, run_first, run_last;
  int wall_n, wall_first, wall_last;
  int valid0, side0;

  wall_trace_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vsync   (vsync),
    .i_hpos  (i_hpos),
    .i_vpos  (i_vpos),
    .i_side  (i_side),
    .i_size  (i_size),
    .o_run   (o_run),
    .o_row   (o_row),
    .o_wall  (o_wall),
    .o_side  (o_side),
    .o_valid (o_valid)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    int vpos;
    int size;
    int side;
    int row;
    int run_cnt;
    int valid;
    int wall_cnt;
    int wall_lo;
    int wall_hi;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one scanline (hpos 0..h_end); vsync is pulsed for the single cycle hpos==vs_h.
  task automatic run_line(input int v, input int vs_h, input int h_end);
    run_n = 0; run_first = -1; run_last = -1;
    wall_n = 0; wall_first = -1; wall_last = -1;
    valid0 = -1; side0 = -1;
    for (int h = 0; h <= h_end; h++) begin
      i_hpos = 10'(h);
      i_vpos = 10'(v);
      vsync  = (h == vs_h);
      @(posedge clk);
      #1;
      if (h == 0) begin
        valid0 = int'(o_valid);
        side0  = int'(o_side);
      end
      if (o_run) begin
        run_n++;
        if (run_first < 0) run_first = h;
        run_last = h;
      end
      if (o_wall) begin
        wall_n++;
        if (wall_first < 0) wall_first = h;
        wall_last = h;
      end
    end
    vsync = 1'b0;
  endtask

  initial begin
    vecs[0] = '{10,   200, 1, 11,  150, 1, 200, 220, 419};
    vecs[1] = '{524,  101, 0, 0,   150, 1, 100, 270, 369};
    vecs[2] = '{100, 2047, 1, 101, 150, 1, 640, 0,   639};
    vecs[3] = '{479,  300, 1, 102, 0,   0, 0,   0,   0};
    vecs[4] = '{200,    0, 1, 201, 150, 1, 0,   0,   0};
    vecs[5] = '{300,  640, 0, 301, 150, 1, 640, 0,   639};

    reset_n = 1'b0;
    vsync   = 1'b0;
    i_hpos  = '0;
    i_vpos  = '0;
    i_side  = 1'b0;
    i_size  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_run",   int'(o_run),   0);
    chk("reset_row",   int'(o_row),   0);
    chk("reset_wall",  int'(o_wall),  0);
    chk("reset_side",  int'(o_side),  0);
    chk("reset_valid", int'(o_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      i_size = 11'(vecs[i].size);
      i_side = vecs[i].side[0];
      run_line(vecs[i].vpos, -1, 799);
      chk($sformatf("v%0d_row", i), int'(o_row), vecs[i].row);
      chk($sformatf("v%0d_run_cnt", i), run_n, vecs[i].run_cnt);
      if (vecs[i].run_cnt > 0) begin
        chk($sformatf("v%0d_run_first", i), run_first, 640);
        chk($sformatf("v%0d_run_last", i), run_last, 789);
      end
      i_size = '0;
      i_side = 1'b0;
      run_line((vecs[i].vpos == 524) ? 0 : vecs[i].vpos + 1, -1, 799);
      chk($sformatf("v%0d_valid", i), valid0, vecs[i].valid);
      if (vecs[i].valid != 0)
        chk($sformatf("v%0d_side", i), side0, vecs[i].side);
      chk($sformatf("v%0d_wall_cnt", i), wall_n, vecs[i].wall_cnt);
      if (vecs[i].wall_cnt > 0) begin
        chk($sformatf("v%0d_wall_lo", i), wall_first, vecs[i].wall_lo);
        chk($sformatf("v%0d_wall_hi", i), wall_last, vecs[i].wall_hi);
      end
    end

    // vsync at hpos 700 aborts the trace: no capture, next line shows nothing.
    i_size = 11'd200;
    i_side = 1'b1;
    run_line(20, 700, 799);
    chk("vs_run_cnt",  run_n,     60);
    chk("vs_run_last", run_last,  699);
    chk("vs_row",      int'(o_row), 21);
    i_size = '0;
    i_side = 1'b0;
    run_line(21, -1, 799);
    chk("vs_next_valid", valid0, 0);
    chk("vs_next_wall",  wall_n, 0);

    // Asynchronous reset mid-run with the clock stopped.
    run_line(30, -1, 700);
    chk("ar_pre_run", int'(o_run), 1);
    chk("ar_pre_row", int'(o_row), 31);
    chk("ar_pre_valid", int'(o_valid), 1);
    @(negedge clk);
    clk_en = 1'b0;
    #20;
    reset_n = 1'b0;
    #1;
    chk("ar_run",   int'(o_run),   0);
    chk("ar_row",   int'(o_row),   0);
    chk("ar_wall",  int'(o_wall),  0);
    chk("ar_side",  int'(o_side),  0);
    chk("ar_valid", int'(o_valid), 0);
    #5;
    reset_n = 1'b1;
    clk_en  = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
